// File: rtl/sounder_frame_streamer_if.sv
// Stream and BRAM read-port bundle for the sounding-frame streamer.
// The master side owns the AXI4-Stream outputs and drives the BRAM read port.
interface sounder_frame_streamer_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] M00_AXIS_tdata;
  logic                  M00_AXIS_tvalid;
  logic                  M00_AXIS_tready;
  logic                  M00_AXIS_tlast;
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport master (
    output M00_AXIS_tdata, M00_AXIS_tvalid, M00_AXIS_tlast,
    input  M00_AXIS_tready,
    output bram_en, bram_addr,
    input  bram_dout
  );

  modport slave (
    input  M00_AXIS_tdata, M00_AXIS_tvalid, M00_AXIS_tlast,
    output M00_AXIS_tready,
    input  bram_en, bram_addr,
    output bram_dout
  );
endinterface

// File: rtl/sounder_frame_streamer.sv
// Plays a stored frame from a BRAM read port out as an AXI4-Stream, FRAME_LEN beats
// with TLAST on the final beat, then a fixed idle gap before the next frame.
module sounder_frame_streamer #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int GAP_CYCLES = 65,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_aresetn,
  input  logic                     enable,
  sounder_frame_streamer_if.master m_if,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [1:0]               o_dbg_state
);
  // Handshake: a beat moves on a cycle where tvalid and tready are both high. tvalid,
  // tdata and tlast are register outputs that hold until that transfer; tready only
  // steers the BRAM read issue, never the stream outputs.

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW1-1:0] LAST_ADDR = AW1'(FRAME_LEN - 1);
  localparam logic [AW1-1:0] END_ADDR  = AW1'(FRAME_LEN);
  localparam logic [GW-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [AW1-1:0]        r_rd_addr;
  logic [GW-1:0]         r_gap_cnt;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic [1:0]            r_occ;
  logic [CNT_WIDTH-1:0]  r_frame_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_last_xfer;
  logic [1:0]            w_room;
  logic                  w_wr_idx;

  assign w_pop       = (r_occ != 2'd0) && m_if.M00_AXIS_tready;
  assign w_push      = r_inflight;
  assign w_last_xfer = w_pop && r_buf_last[0];
  // Slots committed for next cycle: entries left after this cycle's pop plus the read
  // returning now. Counting the pop keeps one read per cycle when the sink never stalls.
  assign w_room      = r_occ - {1'b0, w_pop} + {1'b0, r_inflight};
  assign w_issue     = (r_state == S_STREAM) && (r_rd_addr < END_ADDR) && (w_room < 2'd2);
  assign w_wr_idx    = 1'(r_occ - {1'b0, w_pop});

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_last_xfer) begin
          if (GAP_CYCLES > 0)  w_next = S_GAP;
          else if (!enable)    w_next = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = enable ? S_STREAM : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_rd_addr       <= '0;
      r_gap_cnt       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_frame_count   <= '0;
    end else begin
      // The address restarts whenever a frame is not being fetched, so every frame
      // begins at zero whether it follows IDLE, GAP or a zero-length gap.
      if ((r_state != S_STREAM) || w_last_xfer) begin
        r_rd_addr <= '0;
      end else if (w_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
      r_gap_cnt       <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rd_addr == LAST_ADDR);
      if (w_last_xfer) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  // Two-entry output buffer: entry 0 is the head presented on the stream.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_occ         <= '0;
    end else begin
      r_occ <= r_occ - {1'b0, w_pop} + {1'b0, w_push};
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_last[0] <= r_buf_last[1];
      end
      if (w_push) begin
        r_buf_data[w_wr_idx] <= m_if.bram_dout;
        r_buf_last[w_wr_idx] <= r_inflight_last;
      end
    end
  end

  assign m_if.bram_en         = w_issue;
  assign m_if.bram_addr       = r_rd_addr[ADDR_WIDTH-1:0];
  assign m_if.M00_AXIS_tvalid = (r_occ != 2'd0);
  assign m_if.M00_AXIS_tdata  = r_buf_data[0];
  assign m_if.M00_AXIS_tlast  = r_buf_last[0] && (r_occ != 2'd0);
  assign busy                 = (r_state != S_IDLE);
  assign frame_count          = r_frame_count;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_sounder_frame_streamer.sv
// Bench for sounder_frame_streamer: a full-size instance (1024 beats, 65-cycle gap) and a
// small instance (4 beats, no gap), each fed by a BRAM model holding data[i] = i.
module tb_sounder_frame_streamer;
  localparam int DW   = 96;
  localparam int CW   = 16;
  localparam int AW_A = 10;
  localparam int FL_A = 1024;
  localparam int GAP_A = 65;
  localparam int AW_B = 2;
  localparam int FL_B = 4;
  localparam int QW   = DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, en_a, en_b;
  logic busy_a, busy_b;
  logic [CW-1:0] fc_a, fc_b;
  logic [1:0] dbg_a, dbg_b;
  int pct_a, pct_b;
  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q_a[$];
  logic [QW-1:0] exp_q_b[$];
  logic [CW-1:0] exp_fc_a = '0;
  logic [CW-1:0] exp_fc_b = '0;

  sounder_frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_A)) if_a();
  sounder_frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B)) if_b();

  sounder_frame_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW_A), .FRAME_LEN(FL_A), .GAP_CYCLES(GAP_A), .CNT_WIDTH(CW)
  ) dut_a (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_a_n), .enable(en_a), .m_if(if_a),
    .busy(busy_a), .frame_count(fc_a), .o_dbg_state(dbg_a)
  );

  sounder_frame_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW_B), .FRAME_LEN(FL_B), .GAP_CYCLES(0), .CNT_WIDTH(CW)
  ) dut_b (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_b_n), .enable(en_b), .m_if(if_b),
    .busy(busy_b), .frame_count(fc_b), .o_dbg_state(dbg_b)
  );

  // BRAM models: one-cycle read latency, contents equal to the address.
  always @(posedge clk) begin
    if (if_a.bram_en) if_a.bram_dout <= DW'(if_a.bram_addr);
    if (if_b.bram_en) if_b.bram_dout <= DW'(if_b.bram_addr);
  end

  // Sink ready drivers, randomised at the configured percentage.
  always @(posedge clk) begin
    #1;
    if_a.M00_AXIS_tready = (int'($urandom_range(0, 99)) < pct_a);
    if_b.M00_AXIS_tready = (int'($urandom_range(0, 99)) < pct_b);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_a(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < FL_A; i++) exp_q_a.push_back({(i == FL_A - 1), DW'(i)});
  endtask

  task automatic push_b(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < FL_B; i++) exp_q_b.push_back({(i == FL_B - 1), DW'(i)});
  endtask

  task automatic wait_fc(input int sel, input logic [CW-1:0] target, input int budget, input string name);
    int n = 0;
    while (((sel == 0) ? fc_a : fc_b) !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (sel == 0) ? fc_a : fc_b, target);
  endtask

  task automatic wait_idle(input int sel, input int budget, input string name);
    int n = 0;
    while (((sel == 0) ? busy_a : busy_b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (sel == 0) ? busy_a : busy_b, 1'b0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_tvalid"}, if_a.M00_AXIS_tvalid, 1'b0);
    check({tag, "_tdata"},  if_a.M00_AXIS_tdata, '0);
    check({tag, "_tlast"},  if_a.M00_AXIS_tlast, 1'b0);
    check({tag, "_bram_en"}, if_a.bram_en, 1'b0);
    check({tag, "_bram_addr"}, if_a.bram_addr, '0);
    check({tag, "_busy"}, busy_a, 1'b0);
    check({tag, "_fc"}, fc_a, '0);
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic          stall_a = 1'b0, fc_pend_a = 1'b0;
  logic [QW-1:0] held_a;
  logic [CW-1:0] fc_model_a = '0;
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (!rst_a_n) begin
      exp_q_a.delete();
      stall_a = 1'b0;
      fc_pend_a = 1'b0;
      fc_model_a = '0;
    end else begin
      if (fc_pend_a) begin
        check("fc_a_after_last", fc_a, fc_model_a);
        fc_pend_a = 1'b0;
      end
      if (stall_a)
        check("stall_hold_a", {if_a.M00_AXIS_tvalid, if_a.M00_AXIS_tlast, if_a.M00_AXIS_tdata},
              {1'b1, held_a});
      if (if_a.M00_AXIS_tvalid && if_a.M00_AXIS_tready) begin
        if (exp_q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_a_unexpected got=%0h expected=none",
                   {if_a.M00_AXIS_tlast, if_a.M00_AXIS_tdata});
        end else begin
          e = exp_q_a.pop_front();
          check("beat_a", {if_a.M00_AXIS_tlast, if_a.M00_AXIS_tdata}, e);
          if (e[QW-1]) begin
            fc_model_a = fc_model_a + 1'b1;
            fc_pend_a = 1'b1;
          end
        end
      end
      stall_a = if_a.M00_AXIS_tvalid && !if_a.M00_AXIS_tready;
      held_a  = {if_a.M00_AXIS_tlast, if_a.M00_AXIS_tdata};
    end
  end

  logic          stall_b = 1'b0, fc_pend_b = 1'b0, nextread_b = 1'b0, nextidle_b = 1'b0;
  logic [QW-1:0] held_b;
  logic [CW-1:0] fc_model_b = '0;
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (!rst_b_n) begin
      exp_q_b.delete();
      stall_b = 1'b0;
      fc_pend_b = 1'b0;
      nextread_b = 1'b0;
      nextidle_b = 1'b0;
      fc_model_b = '0;
    end else begin
      if (fc_pend_b) begin
        check("fc_b_after_last", fc_b, fc_model_b);
        fc_pend_b = 1'b0;
      end
      if (nextread_b) begin
        check("gap0_next_read_b", {if_b.bram_en, if_b.bram_addr}, {1'b1, 2'd0});
        nextread_b = 1'b0;
      end
      if (nextidle_b) begin
        check("gap0_idle_b", busy_b, 1'b0);
        nextidle_b = 1'b0;
      end
      if (stall_b)
        check("stall_hold_b", {if_b.M00_AXIS_tvalid, if_b.M00_AXIS_tlast, if_b.M00_AXIS_tdata},
              {1'b1, held_b});
      if (if_b.M00_AXIS_tvalid && if_b.M00_AXIS_tready) begin
        if (exp_q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_b_unexpected got=%0h expected=none",
                   {if_b.M00_AXIS_tlast, if_b.M00_AXIS_tdata});
        end else begin
          e = exp_q_b.pop_front();
          check("beat_b", {if_b.M00_AXIS_tlast, if_b.M00_AXIS_tdata}, e);
          if (e[QW-1]) begin
            fc_model_b = fc_model_b + 1'b1;
            fc_pend_b = 1'b1;
            if (en_b) nextread_b = 1'b1;
            else      nextidle_b = 1'b1;
          end
        end
      end
      stall_b = if_b.M00_AXIS_tvalid && !if_b.M00_AXIS_tready;
      held_b  = {if_b.M00_AXIS_tlast, if_b.M00_AXIS_tdata};
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    int            ready_pct;
    int            frames;
    logic [CW-1:0] exp_fc_delta;
    logic          exp_busy;
  } vec_t;
  localparam int NV = 5;
  vec_t vec [NV];

  initial begin
    int n, bubbles, busy_lows, reads;
    logic [CW-1:0] target;

    vec[0] = '{ready_pct: 100, frames: 1, exp_fc_delta: 16'd1, exp_busy: 1'b0};
    vec[1] = '{ready_pct: 50,  frames: 1, exp_fc_delta: 16'd1, exp_busy: 1'b0};
    vec[2] = '{ready_pct: 100, frames: 2, exp_fc_delta: 16'd2, exp_busy: 1'b0};
    vec[3] = '{ready_pct: 70,  frames: 2, exp_fc_delta: 16'd2, exp_busy: 1'b0};
    vec[4] = '{ready_pct: 30,  frames: 1, exp_fc_delta: 16'd1, exp_busy: 1'b0};

    rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0; pct_a = 100; pct_b = 100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a("reset_a");
    check("reset_b_tvalid", if_b.M00_AXIS_tvalid, 1'b0);
    check("reset_b_busy", busy_b, 1'b0);
    check("reset_b_fc", fc_b, '0);
    @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // First-beat latency, sustained throughput, gap length, then enable dropped mid-frame.
    push_a(2);
    exp_fc_a = exp_fc_a + 16'd2;
    @(posedge clk); #1 en_a = 1'b1;
    @(negedge clk);
    check("lat_idle_bram_en", if_a.bram_en, 1'b0);
    @(negedge clk);
    check("lat_read0", {if_a.bram_en, if_a.bram_addr}, {1'b1, 10'd0});
    check("lat_busy", busy_a, 1'b1);
    check("lat_tvalid_c1", if_a.M00_AXIS_tvalid, 1'b0);
    @(negedge clk);
    check("lat_read1", {if_a.bram_en, if_a.bram_addr}, {1'b1, 10'd1});
    check("lat_tvalid_c2", if_a.M00_AXIS_tvalid, 1'b0);
    @(negedge clk);
    check("lat_first_beat", {if_a.M00_AXIS_tvalid, if_a.M00_AXIS_tdata}, {1'b1, 96'd0});
    n = 0; bubbles = 0;
    while (!(if_a.M00_AXIS_tvalid && if_a.M00_AXIS_tlast) && n < 3 * FL_A) begin
      @(negedge clk);
      n++;
      if (!if_a.M00_AXIS_tvalid) bubbles++;
    end
    check("frame_cycles_a", n, FL_A - 1);
    check("throughput_bubbles_a", bubbles, 0);
    n = 0; busy_lows = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy_a) busy_lows++;
    end while (!if_a.M00_AXIS_tvalid && n < 500);
    check("gap_idle_cycles_a", n - 1, GAP_A + 2);
    check("gap_busy_a", busy_lows, 0);
    @(posedge clk); #1 en_a = 1'b0;
    n = 0;
    while (!(if_a.M00_AXIS_tvalid && if_a.M00_AXIS_tlast) && n < 3 * FL_A) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (!busy_a) break;
      n++;
    end
    check("gap_busy_len_a", n, GAP_A);
    check("seq1_fc_a", fc_a, exp_fc_a);
    check("seq1_queue_empty_a", exp_q_a.size(), 0);

    // Sink stalled from frame start with a one-cycle enable pulse.
    pct_a = 0;
    push_a(1);
    exp_fc_a = exp_fc_a + 16'd1;
    @(posedge clk); #1 en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_a.bram_en) reads++;
    end
    check("stall_reads_a", reads, 2);
    check("stall_head_a", {if_a.M00_AXIS_tvalid, if_a.M00_AXIS_tlast, if_a.M00_AXIS_tdata},
          {1'b1, 1'b0, 96'd0});
    pct_a = 100;
    wait_idle(0, 3000, "pulse_idle_a");
    check("pulse_fc_a", fc_a, exp_fc_a);
    check("pulse_queue_empty_a", exp_q_a.size(), 0);

    // Asynchronous reset in the middle of a frame.
    push_a(1);
    @(posedge clk); #1 en_a = 1'b1;
    n = 0;
    while (!(if_a.M00_AXIS_tvalid && if_a.M00_AXIS_tdata == DW'(500)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("beat500_reached", if_a.M00_AXIS_tdata, 96'd500);
    #2 rst_a_n = 1'b0;
    #1 check_reset_a("async_reset_a");
    @(negedge clk);
    @(posedge clk); #1 rst_a_n = 1'b1;
    exp_fc_a = '0;
    push_a(1);
    exp_fc_a = exp_fc_a + 16'd1;
    @(negedge clk);
    check("post_reset_fc_a", fc_a, '0);
    @(posedge clk); #1 en_a = 1'b0;
    wait_idle(0, 3000, "post_reset_idle_a");
    check("post_reset_frame_fc_a", fc_a, exp_fc_a);
    check("post_reset_queue_empty_a", exp_q_a.size(), 0);

    // Table-driven scenarios: random sink ready, enable held until the frame count is reached.
    for (int v = 0; v < NV; v++) begin
      pct_a = vec[v].ready_pct;
      push_a(vec[v].frames);
      target = exp_fc_a + vec[v].exp_fc_delta;
      @(posedge clk); #1 en_a = 1'b1;
      wait_fc(0, target, vec[v].frames * (FL_A * 100 / vec[v].ready_pct + 400), "table_fc_reach");
      @(posedge clk); #1 en_a = 1'b0;
      wait_idle(0, 500, "table_idle");
      check("table_busy", busy_a, vec[v].exp_busy);
      check("table_fc", fc_a, target);
      check("table_queue_empty", exp_q_a.size(), 0);
      exp_fc_a = target;
    end

    // Zero-gap instance: back-to-back frames, then a run with a random sink.
    pct_b = 100;
    push_b(3);
    @(posedge clk); #1 en_b = 1'b1;
    wait_fc(1, exp_fc_b + 16'd2, 200, "b_fc_reach_2");
    @(posedge clk); #1 en_b = 1'b0;
    wait_idle(1, 200, "b_idle_1");
    exp_fc_b = exp_fc_b + 16'd3;
    check("b_fc_run1", fc_b, exp_fc_b);
    check("b_queue_empty_1", exp_q_b.size(), 0);

    pct_b = 50;
    push_b(4);
    @(posedge clk); #1 en_b = 1'b1;
    wait_fc(1, exp_fc_b + 16'd3, 600, "b_fc_reach_3");
    @(posedge clk); #1 en_b = 1'b0;
    wait_idle(1, 300, "b_idle_2");
    exp_fc_b = exp_fc_b + 16'd4;
    check("b_fc_run2", fc_b, exp_fc_b);
    check("b_queue_empty_2", exp_q_b.size(), 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/sounder_frame_streamer.md
Name: sounder_frame_streamer

Overview:
AXI4-Stream master that plays a stored 96-bit sounding frame out of a block RAM read port into custom_complex_mult's S00_AXIS input. Each frame is FRAME_LEN beats with TLAST on the final beat, followed by a programmable idle gap. This block is the transmit end of the S00_AXIS stream that custom_complex_mult receives, replacing the bench-driven source in hardware.

Parameters:
DATA_WIDTH, 96, stream and BRAM data width (bits)
ADDR_WIDTH, 10, BRAM address width
FRAME_LEN, 1024, beats per frame (2..2^ADDR_WIDTH)
GAP_CYCLES, 65, idle cycles between frames (0 allowed)
CNT_WIDTH, 16, frame counter width

Ports:
m00_axis_aclk  in  1  sole clock; all logic on its rising edge
m00_axis_aresetn  in  1  reset, asynchronous assert, active-low
enable  in  1  level; high = stream frames continuously
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR_WIDTH  BRAM read address
bram_dout  in  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after bram_en
M00_AXIS_tdata  out  DATA_WIDTH  stream data
M00_AXIS_tvalid  out  1  stream valid
M00_AXIS_tready  in  1  stream ready
M00_AXIS_tlast  out  1  high on beat FRAME_LEN-1
busy  out  1  high in STREAM or GAP
frame_count  out  CNT_WIDTH  completed frames, wraps

Behaviour:
- Reset (m00_axis_aresetn low, async): state=IDLE; bram_en=0, bram_addr=0, tvalid=0, tlast=0, tdata=0, busy=0, frame_count=0; buffer emptied, all counters 0. Reset mid-frame aborts the frame; no partial-frame completion after release.
- States: IDLE, STREAM, GAP.
- IDLE: enable=1 -> STREAM (next cycle). bram_en=0.
- STREAM: read address counter rd_addr runs 0..FRAME_LEN-1; one read issued (bram_en=1, bram_addr=rd_addr) per cycle when (buffer occupancy + reads in flight) < 2 and rd_addr not yet past FRAME_LEN-1. Returned data enters a 2-entry output buffer; head drives tdata/tvalid.
- Latency: first tvalid 2 cycles after entering STREAM (read cycle + BRAM latency) with tready held high.
- Throughput: 1 beat/cycle sustained with tready=1.
- AXIS rules: beat transfers on tvalid&tready. Once tvalid=1, tvalid/tdata/tlast hold stable until transfer. No combinational path from tready to tvalid/tdata.
- tlast=1 exactly on the beat carrying address FRAME_LEN-1; beat order strictly ascending address, no drops, no duplicates under any tready pattern.
- Transfer of the tlast beat: frame_count += 1 (mod 2^CNT_WIDTH); -> GAP if GAP_CYCLES>0, else directly re-evaluate enable as below.
- GAP: tvalid=0, bram_en=0 for exactly GAP_CYCLES cycles; then enable=1 -> STREAM (rd_addr=0), enable=0 -> IDLE.
- enable deasserted during STREAM: current frame completes in full, then GAP, then IDLE. Enable reasserted before GAP ends: next frame starts, no extra delay.
- GAP_CYCLES=0 and enable=1: next frame's first read issued the cycle after the tlast transfer.
- busy=1 in STREAM and GAP, 0 in IDLE.
- Width rules: rd_addr and beat counter ADDR_WIDTH+1 bits wide internally so FRAME_LEN=2^ADDR_WIDTH terminates correctly; bram_addr is the lower ADDR_WIDTH bits.

Test Plan:
- BRAM preloaded with data[i]=i, tready=1, enable=1 from reset release: tdata 0,1,...,1023 on consecutive cycles, tlast only on 1023, then tvalid=0 for 65 cycles, next frame starts at 0; frame_count 0->1 on tlast transfer.
- tready random (50% LFSR): 1024 beats received in order 0..1023, tvalid never drops while tready=0, tdata stable while stalled, exactly one tlast per frame.
- tready=0 for 20 cycles from frame start: at most 2 reads issued, tdata=0 held; on tready=1, stream resumes 0,1,2,... with no gaps beyond buffer refill.
- enable pulsed high 1 cycle: exactly one frame sent, then 65 gap cycles, then IDLE with busy=0; frame_count=1.
- GAP_CYCLES=0, FRAME_LEN=4, enable=1: tdata 0,1,2,3,0,1,2,3 back-to-back, tlast on each 3, frame_count increments every 4 beats.
- Reset asserted at beat 500: all outputs 0 immediately (async); after release with enable=1, stream restarts at address 0, frame_count=0.
